// File: rtl/adc_share_pkg.sv
// Shared types and helpers for the A/D converter sharing scheduler.
// The optional mux-settle delay is enabled with ADC_SHARE_SETTLE_EN.
package adc_share_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int W_DEF      = 8;
  localparam int SETTLE_DEF = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DELIV = 3'd4,
    ACK   = 3'd5
  } state_e;

  // Increment an index modulo n; n need not be a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
  endfunction

endpackage

// File: rtl/adc_share_sched_if.sv
// Converter-side and requester-side signals of the A/D sharing scheduler.
// The scheduler takes the master view; converter and consumers take the slave view.
interface adc_share_sched_if
  import adc_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [IDW-1:0]   mux_sel;
  logic             soc;
  logic             eoc;
  logic [W-1:0]     x;
  logic [W-1:0]     data;
  logic [IDW-1:0]   grant_id;
  logic [N_REQ-1:0] dav_;
  logic [N_REQ-1:0] rfd;
  logic             busy;

  modport master (
    input  req, eoc, x, rfd,
    output mux_sel, soc, data, grant_id, dav_, busy
  );

  modport slave (
    output req, eoc, x, rfd,
    input  mux_sel, soc, data, grant_id, dav_, busy
  );
endinterface

// File: rtl/adc_share_sched_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module rr_pick
  import adc_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   winner,
  output logic             any
);

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    int idx;
    idx    = 32'sd0;
    winner = {IDW{1'b0}};
    any    = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      idx = (idx >= N_REQ) ? (idx - N_REQ) : idx;
      if (req[IDW'(idx)]) begin
        winner = IDW'(idx);
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/adc_share_sched.sv
// Round-robin scheduler sharing one soc/eoc A/D converter among N_REQ requesters.
// Define ADC_SHARE_SETTLE_EN to hold mux_sel for SETTLE extra cycles before soc.
module adc_share_sched
  import adc_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int IDW   = $clog2(N_REQ)
`ifdef ADC_SHARE_SETTLE_EN
  , parameter int SETTLE = SETTLE_DEF
`endif
) (
  input logic              clock,
  input logic              reset,
  adc_share_sched_if.master bus
);

  state_e           state_r;
  state_e           state_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   grant_r;
  logic [IDW-1:0]   winner_s;
  logic             any_s;
  logic [W-1:0]     data_r;
  logic             soc_r;
  logic             busy_r;
  logic [N_REQ-1:0] dav_n_r;
  logic [N_REQ-1:0] dav_n_s;
  logic             rfd_g_s;
  logic             sel_done_s;

  assign rfd_g_s = bus.rfd[grant_r];

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (ptr_r),
    .winner (winner_s),
    .any    (any_s)
  );

`ifdef ADC_SHARE_SETTLE_EN
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  logic [CW-1:0] cnt_r;
  logic          granted_r;

  assign sel_done_s = (cnt_r == {CW{1'b0}});

  // Settle counter; a repeat grant to the same channel needs no settling.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r     <= {CW{1'b0}};
      granted_r <= 1'b0;
    end else if ((state_r == IDLE) && any_s) begin
      granted_r <= 1'b1;
      if (granted_r && (winner_s == grant_r)) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= CW'(SETTLE);
      end
    end else if ((state_r == SEL) && !sel_done_s) begin
      cnt_r <= cnt_r - CW'(32'd1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign sel_done_s = 1'b1;
`endif

  // Next-state logic and the active-low data-available pattern it implies.
  always_comb begin
    state_s = state_r;
    dav_n_s = {N_REQ{1'b1}};
    case (state_r)
      IDLE:    if (any_s)       state_s = SEL;   else state_s = IDLE;
      SEL:     if (sel_done_s)  state_s = START; else state_s = SEL;
      START:   if (!bus.eoc)    state_s = WAIT;  else state_s = START;
      WAIT:    if (bus.eoc)     state_s = DELIV; else state_s = WAIT;
      DELIV:   if (!rfd_g_s)    state_s = ACK;   else state_s = DELIV;
      ACK:     if (rfd_g_s)     state_s = IDLE;  else state_s = ACK;
      default: state_s = IDLE;
    endcase
    for (int i = 0; i < N_REQ; i++) begin
      dav_n_s[i] = !((state_s == DELIV) && (grant_r == IDW'(i)));
    end
  end

  // State, registered outputs, grant capture, sample latch and rr pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= {IDW{1'b0}};
      grant_r <= {IDW{1'b0}};
      data_r  <= {W{1'b0}};
      soc_r   <= 1'b0;
      busy_r  <= 1'b0;
      dav_n_r <= {N_REQ{1'b1}};
    end else begin
      state_r <= state_s;
      soc_r   <= (state_s == START);
      busy_r  <= (state_s != IDLE);
      dav_n_r <= dav_n_s;
      if ((state_r == IDLE) && any_s) begin
        grant_r <= winner_s;
      end
      if ((state_r == WAIT) && bus.eoc) begin
        data_r <= bus.x;
      end
      if ((state_r == ACK) && rfd_g_s) begin
        ptr_r <= IDW'(wrap_inc(int'(grant_r), N_REQ));
      end
    end
  end

  assign bus.mux_sel  = grant_r;
  assign bus.grant_id = grant_r;
  assign bus.soc      = soc_r;
  assign bus.data     = data_r;
  assign bus.dav_     = dav_n_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_adc_share_sched.sv
// Directed self-checking bench for adc_share_sched with a simple soc/eoc converter model.
module tb_adc_share_sched;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   conv_cnt;

`ifdef ADC_SHARE_SETTLE_EN
  localparam int SEL_CYC = 4;
`else
  localparam int SEL_CYC = 1;
`endif

  adc_share_sched_if #(.N_REQ(4), .W(8)) ifc ();

  adc_share_sched dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  // Converter: eoc falls one cycle after soc is seen, rises five cycles later.
  always @(posedge clock) begin
    if (reset) begin
      ifc.eoc  <= 1'b1;
      conv_cnt <= 0;
    end else if (conv_cnt == 0) begin
      if (ifc.soc === 1'b1) begin
        ifc.eoc  <= 1'b0;
        conv_cnt <= 5;
      end
    end else begin
      conv_cnt <= conv_cnt - 1;
      if (conv_cnt == 1) ifc.eoc <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Apply req for one sampling edge, then count negedges of stable mux_sel before soc.
  task automatic measure(input logic [3:0] rv, input int who, input int exp_sel, input string tag);
    int cnt;
    int n;
    cnt = 0;
    n   = 0;
    ifc.req = rv;
    @(negedge clock);
    ifc.req = 4'b0000;
    while (ifc.soc !== 1'b1 && n < 20) begin
      if (ifc.mux_sel === 2'(who) && ifc.busy === 1'b1) cnt++;
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(cnt), 32'(exp_sel));
    chk({tag, "_mux"}, 32'(ifc.mux_sel), 32'(who));
  endtask

  // Wait for delivery to requester who, check it, then run the rfd 1->0->1 handshake.
  task automatic do_xfer(input int who, input logic [7:0] val, input bit foreign);
    logic [3:0] exp_dav;
    int n;
    exp_dav = 4'b1111 & ~(4'b0001 << who);
    n = 0;
    while (ifc.dav_ === 4'b1111 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("dav_wait", 32'(n < 60), 32'd1);
    chk("dav", 32'(ifc.dav_), 32'(exp_dav));
    chk("grant_id", 32'(ifc.grant_id), 32'(who));
    chk("data", 32'(ifc.data), 32'(val));
    if (foreign) begin
      ifc.rfd = ~exp_dav;
      repeat (3) @(negedge clock);
      chk("foreign_dav", 32'(ifc.dav_), 32'(exp_dav));
      chk("foreign_busy", 32'(ifc.busy), 32'd1);
      ifc.rfd = 4'b1111;
      @(negedge clock);
      chk("foreign_dav2", 32'(ifc.dav_), 32'(exp_dav));
    end
    ifc.rfd[who] = 1'b0;
    @(negedge clock);
    chk("ack_dav", 32'(ifc.dav_), 32'hF);
    chk("ack_busy", 32'(ifc.busy), 32'd1);
    @(negedge clock);
    chk("ack_hold", 32'(ifc.busy), 32'd1);
    ifc.rfd[who] = 1'b1;
    @(negedge clock);
    chk("idle_busy", 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    int n;
    clock    = 1'b0;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    ifc.req  = 4'b0000;
    ifc.rfd  = 4'b1111;
    ifc.x    = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_soc", 32'(ifc.soc), 32'd0);
    chk("rst_dav", 32'(ifc.dav_), 32'hF);
    chk("rst_data", 32'(ifc.data), 32'd0);
    chk("rst_mux", 32'(ifc.mux_sel), 32'd0);
    chk("rst_gid", 32'(ifc.grant_id), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);

    // Single request with latency and soc duration checks.
    ifc.x = 8'hA5;
    measure(4'b0100, 2, SEL_CYC, "single_sel");
    @(negedge clock);
    chk("soc_hold", 32'(ifc.soc), 32'd1);
    @(negedge clock);
    chk("soc_drop", 32'(ifc.soc), 32'd0);
    chk("wait_dav", 32'(ifc.dav_), 32'hF);
    do_xfer(2, 8'hA5, 1'b0);
    chk("single_mux_hold", 32'(ifc.mux_sel), 32'd2);

    // Round robin with all requests held, starting from a fresh pointer.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset   = 1'b0;
    ifc.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      ifc.x = 8'(8'h10 + k);
      do_xfer(k % 4, 8'(8'h10 + k), 1'b0);
    end
    ifc.req = 4'b0000;

    // Pointer resume: after serving 1, requester 0 wins over 1.
    ifc.x   = 8'h3C;
    ifc.req = 4'b0010;
    do_xfer(1, 8'h3C, 1'b0);
    ifc.x   = 8'hC3;
    ifc.req = 4'b0011;
    do_xfer(0, 8'hC3, 1'b0);
    ifc.req = 4'b0000;

    // Foreign rfd toggles do not affect delivery to requester 3.
    ifc.x   = 8'h5A;
    ifc.req = 4'b1000;
    do_xfer(3, 8'h5A, 1'b1);
    ifc.req = 4'b0000;

    // Mux settle: new channel vs repeated channel.
    ifc.x = 8'h11;
    measure(4'b0010, 1, SEL_CYC, "settle_g1");
    do_xfer(1, 8'h11, 1'b0);
    ifc.x = 8'h22;
    measure(4'b0100, 2, SEL_CYC, "settle_g2");
    do_xfer(2, 8'h22, 1'b0);
    ifc.x = 8'h33;
    measure(4'b0100, 2, 1, "settle_rep");
    do_xfer(2, 8'h33, 1'b0);

    // Reset during WAIT; pointer was 3, requester 0 is in conversion.
    ifc.x   = 8'h77;
    ifc.req = 4'b0001;
    @(negedge clock);
    ifc.req = 4'b0000;
    n = 0;
    while (ifc.soc !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
    end
    while (ifc.soc !== 1'b0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("mid_reach_wait", 32'(n < 30), 32'd1);
    chk("mid_gid", 32'(ifc.grant_id), 32'd0);
    chk("mid_busy", 32'(ifc.busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_soc", 32'(ifc.soc), 32'd0);
    chk("mid_rst_dav", 32'(ifc.dav_), 32'hF);
    chk("mid_rst_data", 32'(ifc.data), 32'd0);
    chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
    chk("mid_rst_gid", 32'(ifc.grant_id), 32'd0);
    ifc.x   = 8'h9E;
    ifc.req = 4'b1001;
    do_xfer(0, 8'h9E, 1'b0);
    ifc.x   = 8'hE9;
    ifc.req = 4'b1000;
    do_xfer(3, 8'hE9, 1'b0);
    ifc.req = 4'b0000;
    repeat (2) @(negedge clock);
    chk("final_busy", 32'(ifc.busy), 32'd0);
    chk("final_dav", 32'(ifc.dav_), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_share_sched.md
Name: adc_share_sched

Overview:
- Round-robin scheduler that shares one soc/eoc A/D converter among N_REQ requesters.
- Per grant: selects the analog mux channel, runs one soc/eoc conversion and latches the sample.
- Delivers the sample to the granted requester only, over a dav_/rfd handshake.
- Sits between the converter (plus its input mux) and the consumer blocks.

Parameters:
- N_REQ, 4, number of requesters/channels (2..8).
- W, 8, sample width.
- IDW, $clog2(N_REQ), width of channel/requester index.
- SETTLE, 3, mux settling cycles (used only with SETTLE_EN).

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester; bit i high = requester i wants one sample.
- mux_sel  out  IDW  analog mux channel select.
- soc  out  1  start of conversion to converter.
- eoc  in  1  end of conversion from converter.
- x  in  W  converter output, valid while eoc=1 after a conversion.
- data  out  W  latched sample, shared bus to all requesters.
- grant_id  out  IDW  index of current/last granted requester.
- dav_  out  N_REQ  active-low data-available, one per requester.
- rfd  in  N_REQ  ready-for-data per requester (1 = ready, drops to 0 to acknowledge).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (clock edge with reset=1) overrides all other activity:
  - state=IDLE, soc=0, dav_=all ones, data=0, mux_sel=0, grant_id=0, busy=0, rr pointer ptr=0.
  - Applies mid-transaction too; the pending requester gets no data.
- IDLE:
  - If req==0, stay.
  - Else winner = first i with req[i]=1, searching ptr, ptr+1, ... with wrap modulo N_REQ.
  - Next cycle: grant_id=mux_sel=winner, state=SEL.
- SEL: go to START next cycle (mux held one cycle before soc).
- START:
  - soc=1; stay until eoc==0 is sampled, then go to WAIT.
  - If eoc is already 0 at entry, START still lasts exactly one cycle.
- WAIT:
  - soc=0; stay until eoc==1.
  - On that edge: data<=x, state=DELIV.
- DELIV: dav_[grant_id]=0, all other dav_ bits stay 1; stay until rfd[grant_id]==0.
- ACK:
  - dav_[grant_id]=1; stay until rfd[grant_id]==1.
  - Then ptr<=grant_id+1 (wrapping N_REQ-1 -> 0), state=IDLE.
- Latency with SETTLE_EN off: req seen in IDLE -> soc=1 two cycles later.
- req is sampled only in IDLE. Dropping req after grant does not abort the transaction.
- A requester holding req high is re-queued; round-robin guarantees that with all req high the order is 0,1,2,...,N_REQ-1,0.
- rfd of non-granted requesters is ignored at all times.
- mux_sel and data hold their values in IDLE (last grant) until the next grant.
- Only one dav_ bit is ever low at a time.
- Index width: values >= N_REQ are never produced; for non-power-of-2 N_REQ the pointer wraps explicitly.

Optional Feature:
- Macro: ADC_SHARE_SETTLE_EN.
- Defined:
  - SEL loads a down-counter with SETTLE and stays until it reaches 0, giving SETTLE+1 cycles of stable mux_sel before soc.
  - Exception: the settle wait is skipped (1 cycle) when winner equals the previous grant_id and a previous grant exists since reset.
- Undefined: SEL always lasts 1 cycle, and no counter is synthesized.

Decomposition:
- Package adc_share_pkg holds:
  - state enum (IDLE, SEL, START, WAIT, DELIV, ACK);
  - default parameter constants;
  - a function for wrapping index increment.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req, ptr. Outputs: winner, any.

Test Plan:
- Single request: req=4'b0100, converter model eoc drops 1 cycle after soc and rises 5 cycles later with x=8'hA5 -> mux_sel=2, soc high until eoc=0, data=8'hA5, only dav_[2]=0, released after rfd[2] 1->0->1, busy=0 after.
- Round-robin fairness: req=4'b1111 held for 8 transactions -> grant_id sequence 0,1,2,3,0,1,2,3.
- Pointer resume: after serving 1, req=4'b0011 -> next grant is 0 (wrap from ptr=2), not 1.
- Ignore foreign rfd: during DELIV for requester 3, toggle rfd[0..2] -> dav_[3] stays 0 and state unchanged until rfd[3]=0.
- Reset mid-operation: assert reset in WAIT -> next edge soc=0, dav_=4'b1111, data=0, busy=0; a later req=4'b1000 is served normally starting from ptr=0.
- ADC_SHARE_SETTLE_EN, SETTLE=3: grant 1 then grant 2 -> 4 cycles of mux_sel=2 before soc; a repeat grant to 2 -> soc after 1 cycle.
